// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and issue-side bundle of the decode queue.
// master = fetch/issue driver, slave = the queue itself.
interface decode_queue_if #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int PC_W    = 32
);
  logic [1:0]              in_num;
  logic [32*FETCH_W-1:0]   in_instr;
  logic [PC_W*FETCH_W-1:0] in_pc;
  logic                    in_ready;
  logic [ISSUE_W-1:0]      out_valid;
  logic [32*ISSUE_W-1:0]   out_instr;
  logic [PC_W*ISSUE_W-1:0] out_pc;
  logic [ISSUE_W-1:0]      out_regwrite;
  logic [5*ISSUE_W-1:0]    out_writereg;
  logic [ISSUE_W-1:0]      out_memrd;
  logic [ISSUE_W-1:0]      out_memwr;
  logic [ISSUE_W-1:0]      out_branch;
  logic [ISSUE_W-1:0]      out_divmul;
  logic [ISSUE_W-1:0]      out_priv;
  logic [ISSUE_W-1:0]      out_ri;
  logic [1:0]              deq_num;

  modport master (
    output in_num, in_instr, in_pc, deq_num,
    input  in_ready, out_valid, out_instr, out_pc,
    input  out_regwrite, out_writereg, out_memrd,
    input  out_memwr, out_branch, out_divmul,
    input  out_priv, out_ri
  );

  modport slave (
    input  in_num, in_instr, in_pc, deq_num,
    output in_ready, out_valid, out_instr, out_pc,
    output out_regwrite, out_writereg, out_memrd,
    output out_memwr, out_branch, out_divmul,
    output out_priv, out_ri
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: instruction FIFO with multi-slot MIPS32 pre-decode
// and an in-order dual-issue pairing filter.
// Ports: clk, resetn (async, active low), flush, q (slave of
// decode_queue_if: in_num/in_instr/in_pc/in_ready from fetch,
// out_* head view and deq_num toward issue).
// Option: define DECQ_BYPASS_EN for zero-latency fetch-to-decode
// bypass while the queue is empty.
module decode_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int PC_W    = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           flush,
  decode_queue_if.slave  q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       regwrite;
    logic [4:0] wr;
    logic       memrd;
    logic       memwr;
    logic       branch;
    logic       divmul;
    logic       priv;
    logic       ri;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t       d;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    logic       w_rd, w_rt, w_31;
    d    = '0;
    w_rd = 1'b0;
    w_rt = 1'b0;
    w_31 = 1'b0;
    op   = i[31:26];
    rs   = i[25:21];
    rt   = i[20:16];
    rd   = i[15:11];
    sa   = i[10:6];
    fn   = i[5:0];
    casez (op)
      6'b000000: begin
        casez (fn)
          6'h00, 6'h02, 6'h03, 6'h04,
          6'h06, 6'h07, 6'h0a, 6'h0b,
          6'h10, 6'h12, 6'b100???,
          6'h2a, 6'h2b: w_rd = 1'b1;
          6'h08: d.branch = 1'b1;
          6'h09: begin
            d.branch = 1'b1;
            w_31     = 1'b1;
          end
          6'h0c, 6'h0d: d.priv = 1'b1;
          6'h0f, 6'h11, 6'h13: ;
          6'b0110??: d.divmul = 1'b1;
          default: d.ri = 1'b1;
        endcase
      end
      6'b000001: begin
        case (rt)
          5'h00, 5'h01: d.branch = 1'b1;
          5'h10, 5'h11: begin
            d.branch = 1'b1;
            w_31     = 1'b1;
          end
          default: d.ri = 1'b1;
        endcase
      end
      6'b000010: d.branch = 1'b1;
      6'b000011: begin
        d.branch = 1'b1;
        w_31     = 1'b1;
      end
      6'b0001??: d.branch = 1'b1;
      6'b001???: w_rt = 1'b1;
      6'b010000: begin
        if (rs == 5'h00) begin
          d.priv = 1'b1;
          w_rt   = 1'b1;
        end else if (rs == 5'h04) begin
          d.priv = 1'b1;
        end else if (i[25] && fn == 6'h18) begin
          d.priv = 1'b1;
        end else begin
          d.ri = 1'b1;
        end
      end
      6'b011100: begin
        case (fn)
          6'h00, 6'h01,
          6'h04, 6'h05: d.divmul = 1'b1;
          6'h02: begin
            d.divmul = 1'b1;
            w_rd     = 1'b1;
          end
          6'h20, 6'h21: w_rd = 1'b1;
          default: d.ri = 1'b1;
        endcase
      end
      6'b011111: begin
        if (fn == 6'h00 || fn == 6'h04) begin
          w_rt = 1'b1;
        end else if (fn == 6'h20 &&
                     (sa == 5'h02 || sa == 5'h10 ||
                      sa == 5'h18)) begin
          w_rd = 1'b1;
        end else begin
          d.ri = 1'b1;
        end
      end
      6'b100???: begin
        d.memrd = 1'b1;
        w_rt    = 1'b1;
      end
      6'b101???: d.memwr = 1'b1;
      6'b110000: begin
        d.memrd = 1'b1;
        w_rt    = 1'b1;
      end
      default: d.ri = 1'b1;
    endcase
    if (w_31)      d.wr = 5'd31;
    else if (w_rd) d.wr = rd;
    else if (w_rt) d.wr = rt;
    d.regwrite = d.wr != 5'd0;
    return d;
  endfunction

  logic [31:0]     mem_i  [DEPTH];
  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic [31:0]     in_i [FETCH_W];
  logic [PC_W-1:0] in_p [FETCH_W];
  logic [1:0]      in_n;
  logic            accept;
  logic            byp;

  always_comb begin
    for (int j = 0; j < FETCH_W; j++) begin
      in_i[j] = q.in_instr[32*j +: 32];
      in_p[j] = q.in_pc[PC_W*j +: PC_W];
    end
  end

  assign in_n = (q.in_num > 2'(FETCH_W)) ?
                2'(FETCH_W) : q.in_num;
  assign q.in_ready = count <= CW'(DEPTH - FETCH_W);
  assign accept = q.in_ready && !flush;

`ifdef DECQ_BYPASS_EN
  assign byp = resetn && (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  logic [31:0]     v_i   [2];
  logic [PC_W-1:0] v_p   [2];
  logic [1:0]      v_raw;
  dec_t            d     [2];

  // Head view; while bypassing, the incoming slots stand in for it.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      v_i[k]   = mem_i[head + AW'(k)];
      v_p[k]   = mem_pc[head + AW'(k)];
      v_raw[k] = count > CW'(k);
      if (byp) begin
        v_raw[k] = 1'b0;
        if (k < FETCH_W) begin
          v_i[k]   = in_i[k];
          v_p[k]   = in_p[k];
          v_raw[k] = accept && (in_n > 2'(k));
        end
      end
      d[k] = decode(v_i[k]);
    end
  end

  logic       m0, m1, hz, pair_ok;
  logic [1:0] valid;

  assign m0 = d[0].memrd || d[0].memwr;
  assign m1 = d[1].memrd || d[1].memwr;
  assign hz = d[0].regwrite &&
              (d[0].wr == v_i[1][25:21] ||
               d[0].wr == v_i[1][20:16] ||
               d[0].wr == d[1].wr);
  assign pair_ok = !(d[0].divmul || d[0].priv ||
                     (m0 && m1) || d[1].branch ||
                     d[1].priv || d[1].divmul || hz);
  assign valid[0] = v_raw[0];
  assign valid[1] = (ISSUE_W == 2) && v_raw[0] &&
                    v_raw[1] && pair_ok;

  logic [1:0] pref, deq_c, deq_q, skip, enq;

  assign pref  = valid[1] ? 2'd2 : {1'b0, valid[0]};
  assign deq_c = (q.deq_num > pref) ? pref : q.deq_num;
  // Bypassed slots consumed this cycle are never written.
  assign deq_q = byp ? 2'd0 : deq_c;
  assign skip  = byp ? deq_c : 2'd0;
  assign enq   = accept ? (in_n - skip) : 2'd0;

  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (accept && j >= int'(skip) && j < int'(in_n)) begin
        mem_i[tail + AW'(j - int'(skip))]  <= in_i[j];
        mem_pc[tail + AW'(j - int'(skip))] <= in_p[j];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_q);
      tail  <= tail + AW'(enq);
      count <= count + CW'(enq) - CW'(deq_q);
    end
  end

  always_comb begin
    q.out_valid    = '0;
    q.out_instr    = '0;
    q.out_pc       = '0;
    q.out_regwrite = '0;
    q.out_writereg = '0;
    q.out_memrd    = '0;
    q.out_memwr    = '0;
    q.out_branch   = '0;
    q.out_divmul   = '0;
    q.out_priv     = '0;
    q.out_ri       = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      q.out_valid[k]            = valid[k];
      q.out_instr[32*k +: 32]   = v_i[k];
      q.out_pc[PC_W*k +: PC_W]  = v_p[k];
      q.out_regwrite[k]         = d[k].regwrite;
      q.out_writereg[5*k +: 5]  = d[k].wr;
      q.out_memrd[k]            = d[k].memrd;
      q.out_memwr[k]            = d[k].memwr;
      q.out_branch[k]           = d[k].branch;
      q.out_divmul[k]           = d[k].divmul;
      q.out_priv[k]             = d[k].priv;
      q.out_ri[k]               = d[k].ri;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue.
// Model queue tracks entries; head view checked each cycle.
module tb_decode_queue;

  logic clk;
  logic resetn;
  logic flush;

  decode_queue_if #(
    .FETCH_W(2), .ISSUE_W(2), .PC_W(32)
  ) bus ();

  decode_queue #(
    .DEPTH(8), .FETCH_W(2), .ISSUE_W(2), .PC_W(32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .q      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  int          cur_n, cur_dq;
  logic        cur_fl, cur_rdy, cur_byp;
  logic [1:0]  cur_ev;
  logic [31:0] cur_i0, cur_p0, cur_i1, cur_p1;
  int          s;

  localparam logic [31:0] ADDIU = 32'h24020005;
  localparam logic [31:0] ORI   = 32'h34030001;
  localparam logic [31:0] ADDU  = 32'h00222021;
  localparam logic [31:0] SUBU  = 32'h00832823;
  localparam logic [31:0] RSV   = 32'hFC000000;
  localparam logic [31:0] MULT  = 32'h00220018;
  localparam logic [31:0] LW    = 32'h8C260000;
  localparam logic [31:0] SW    = 32'hAC270004;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ai(input int k);
    return 32'h24000000 | ((8 + k % 16) << 16) | k;
  endfunction

  function automatic logic [31:0] pa(input int k);
    return 32'h400 + 4 * k;
  endfunction

  function automatic logic [1:0] ev_of(input int sz);
    return (sz >= 2) ? 2'b11 : (sz == 1 ? 2'b01 : 2'b00);
  endfunction

  task automatic put(input int n,
                     input logic [31:0] i0, p0, i1, p1,
                     input int dq, input logic fl);
    bus.in_num   = 2'(n);
    bus.in_instr = {i1, i0};
    bus.in_pc    = {p1, p0};
    bus.deq_num  = 2'(dq);
    flush        = fl;
    cur_n  = n;
    cur_i0 = i0;
    cur_p0 = p0;
    cur_i1 = i1;
    cur_p1 = p1;
    cur_dq = dq;
    cur_fl = fl;
    cur_rdy = sb.size() <= 6;
    cur_byp = 1'b0;
`ifdef DECQ_BYPASS_EN
    cur_byp = (sb.size() == 0) && !fl;
`endif
    #1;
  endtask

  task automatic incoming(output ent_t inc[$]);
    inc = {};
    if (cur_n > 0) inc.push_back('{cur_i0, cur_p0});
    if (cur_n > 1) inc.push_back('{cur_i1, cur_p1});
  endtask

  // ev: expected valids from the stored queue; evb: same cycle
  // expectation when the bypass path serves an empty queue.
  task automatic view(input logic [1:0] ev,
                      input logic [1:0] evb);
    ent_t vw[$];
    cur_ev = cur_byp ? evb : ev;
    if (cur_byp) incoming(vw);
    else vw = sb;
    chk("valid", 64'(bus.out_valid), 64'(cur_ev));
    chk("ready", 64'(bus.in_ready), 64'(cur_rdy));
    for (int k = 0; k < 2; k++) begin
      if (cur_ev[k] && k < vw.size()) begin
        chk($sformatf("instr%0d", k),
            64'(bus.out_instr[32*k +: 32]), 64'(vw[k].ins));
        chk($sformatf("pc%0d", k),
            64'(bus.out_pc[32*k +: 32]), 64'(vw[k].pc));
      end
    end
  endtask

  task automatic tick();
    ent_t inc[$];
    int   pc, dc;
    incoming(inc);
    pc = (cur_ev == 2'b11) ? 2 : (cur_ev[0] ? 1 : 0);
    dc = (cur_dq < pc) ? cur_dq : pc;
    if (cur_fl) begin
      sb.delete();
    end else if (cur_byp) begin
      sb = inc;
      repeat (dc) void'(sb.pop_front());
    end else begin
      repeat (dc) void'(sb.pop_front());
      if (cur_rdy) foreach (inc[j]) sb.push_back(inc[j]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn       = 1'b0;
    flush        = 1'b0;
    bus.in_num   = '0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
    bus.deq_num  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    bus.in_num   = 2'd2;
    bus.in_instr = {ORI, ADDIU};
    #1;
    chk("rst_valid_in", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.in_num = '0;
    resetn     = 1'b1;
    @(posedge clk);
    #1;

    put(2, ADDIU, 32'h100, ORI, 32'h104, 0, 0);
    view(2'b00, 2'b11);
    tick();
    put(0, 0, 0, 0, 0, 2, 0);
    view(2'b11, 2'b11);
    chk("wreg", 64'(bus.out_writereg), 64'({5'd3, 5'd2}));
    chk("regwr", 64'(bus.out_regwrite), 64'd3);
    tick();

    put(2, ADDU, 32'h200, SUBU, 32'h204, 0, 0);
    view(2'b00, 2'b01);
    tick();
    put(0, 0, 0, 0, 0, 2, 0);
    view(2'b01, 2'b01);
    tick();
    put(0, 0, 0, 0, 0, 1, 0);
    view(2'b01, 2'b01);
    chk("subu_wr", 64'(bus.out_writereg[4:0]), 64'd5);
    tick();

    put(2, RSV, 32'h300, MULT, 32'h304, 0, 0);
    view(2'b00, 2'b01);
    tick();
    put(0, 0, 0, 0, 0, 2, 0);
    view(2'b01, 2'b01);
    chk("ri", 64'(bus.out_ri[0]), 64'd1);
    chk("ri_rw", 64'(bus.out_regwrite[0]), 64'd0);
    tick();
    put(1, ADDU, 32'h308, 0, 0, 0, 0);
    view(2'b01, 2'b01);
    tick();
    put(0, 0, 0, 0, 0, 2, 0);
    view(2'b01, 2'b01);
    chk("divmul", 64'(bus.out_divmul[0]), 64'd1);
    tick();
    put(0, 0, 0, 0, 0, 2, 0);
    view(2'b01, 2'b01);
    tick();

    put(2, LW, 32'h380, SW, 32'h384, 0, 0);
    view(2'b00, 2'b01);
    tick();
    put(0, 0, 0, 0, 0, 2, 0);
    view(2'b01, 2'b01);
    chk("memrd", 64'(bus.out_memrd), 64'd1);
    tick();
    put(0, 0, 0, 0, 0, 2, 0);
    view(2'b01, 2'b01);
    chk("memwr", 64'(bus.out_memwr[0]), 64'd1);
    tick();

    s = 0;
    for (int i = 0; i < 7; i++) begin
      put(1, ai(s), pa(s), 0, 0, 0, 0);
      view(ev_of(sb.size()), 2'b01);
      tick();
      s++;
    end
    put(2, ai(s), pa(s), ai(s+1), pa(s+1), 0, 0);
    view(2'b11, 2'b11);
    tick();
    put(0, 0, 0, 0, 0, 0, 0);
    view(2'b11, 2'b11);
    tick();
    for (int r = 0; r < 4; r++) begin
      put(2, ai(s), pa(s), ai(s+1), pa(s+1), 2, 0);
      view(ev_of(sb.size()), 2'b11);
      if (cur_rdy) s += 2;
      tick();
    end
    while (sb.size() > 0) begin
      put(0, 0, 0, 0, 0, 2, 0);
      view(ev_of(sb.size()), 2'b00);
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0);
    view(2'b00, 2'b00);
    tick();

    put(2, ai(s), pa(s), ai(s+1), pa(s+1), 0, 0);
    view(ev_of(sb.size()), 2'b11);
    tick();
    s += 2;
    put(2, ai(s), pa(s), ai(s+1), pa(s+1), 0, 0);
    view(ev_of(sb.size()), 2'b11);
    tick();
    s += 2;
    put(1, ai(s), pa(s), 0, 0, 0, 0);
    view(ev_of(sb.size()), 2'b01);
    tick();
    s += 1;
    put(2, ai(s), pa(s), ai(s+1), pa(s+1), 2, 1);
    view(2'b11, 2'b11);
    tick();
    put(0, 0, 0, 0, 0, 0, 0);
    view(2'b00, 2'b00);
    tick();

`ifdef DECQ_BYPASS_EN
    put(1, LW, 32'h600, 0, 0, 1, 0);
    view(2'b00, 2'b01);
    chk("byp_memrd", 64'(bus.out_memrd[0]), 64'd1);
    tick();
    put(0, 0, 0, 0, 0, 0, 0);
    view(2'b00, 2'b00);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
